text_pixel_pipe: RTL

Parametrised text-mode pixel generator. It replaces the combinational address/line-select path with a fixed-latency pipeline driven by the horizontal and vertical counters: text-RAM fetch, then font-ROM fetch, then glyph bit serialisation. Glyph size, text grid, counter width and bit order are configurable. The block sits between the VGA timing counters and the pixel-to-RGB stage.

---
 rtl/text_pixel_pipe.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/text_pixel_pipe.sv
// -----------------------------------------------------------------------------
// text_pixel_pipe
//
// Text-mode pixel generator. The horizontal/vertical counters from the VGA
// timing generator are turned into a monochrome pixel through a fixed
// five-edge pipeline:
//   E1  cell decode, text RAM address/strobe
//   E2  external text RAM registers the character code
//   E3  font ROM address {code, glyph_row}/strobe
//   E4  external font ROM registers the glyph row
//   E5  glyph bit selection -> Pixel, video_on
// The pipeline never stalls; one pixel enters and one leaves per clock.
// LATENCY is exported so the timing generator can delay hsync/vsync to match.
//
// Optional feature (macro TEXT_CURSOR_EN): blinking block cursor covering the
// bottom two glyph rows of the selected cell. The blink phase toggles every 32
// frames. When the macro is undefined the cursor ports and logic are absent.
//
// Ports:
//   clock25            in   pixel clock, single clock domain
//   reset_n            in   asynchronous active-low reset
//   HorizontalCounter  in   current pixel column
//   VerticalCounter    in   current line
//   text_addr          out  text RAM read address (row*COLS+col)
//   text_rd            out  text RAM read strobe (visible pixels only)
//   text_data          in   character code, one cycle after text_addr
//   font_addr          out  font ROM address {code, glyph_row}
//   font_rd            out  font ROM read strobe
//   font_data          in   glyph row bits, one cycle after font_addr
//   Pixel              out  monochrome pixel
//   video_on           out  visible-area flag aligned with Pixel
//   cursor_on          in   cursor enable            (TEXT_CURSOR_EN only)
//   cursor_col         in   cursor text column       (TEXT_CURSOR_EN only)
//   cursor_row         in   cursor text row          (TEXT_CURSOR_EN only)
//
// GLYPH_W and GLYPH_H are expected to be at least 2.
// -----------------------------------------------------------------------------
module text_pixel_pipe #(
    parameter int CNT_W     = 10,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int GLYPH_W   = 8,
    parameter int GLYPH_H   = 12,
    parameter int COLS      = 80,
    parameter int ROWS      = 40,
    parameter int CODE_W    = 7,
    parameter int MSB_FIRST = 1,
    localparam int ADDR_W   = $clog2(COLS * ROWS),
    localparam int FONT_AW  = CODE_W + $clog2(GLYPH_H)
`ifdef TEXT_CURSOR_EN
    ,
    localparam int CCOL_W   = $clog2(COLS),
    localparam int CROW_W   = $clog2(ROWS)
`endif
) (
    input  logic                 clock25,
    input  logic                 reset_n,
    input  logic [CNT_W-1:0]     HorizontalCounter,
    input  logic [CNT_W-1:0]     VerticalCounter,
    output logic [ADDR_W-1:0]    text_addr,
    output logic                 text_rd,
    input  logic [CODE_W-1:0]    text_data,
    output logic [FONT_AW-1:0]   font_addr,
    output logic                 font_rd,
    input  logic [GLYPH_W-1:0]   font_data,
`ifdef TEXT_CURSOR_EN
    input  logic                 cursor_on,
    input  logic [CCOL_W-1:0]    cursor_col,
    input  logic [CROW_W-1:0]    cursor_row,
`endif
    output logic                 Pixel,
    output logic                 video_on
);

    localparam int LATENCY = 5;
    localparam int GROW_W  = $clog2(GLYPH_H);
    localparam int BIT_W   = $clog2(GLYPH_W);
    localparam int PROD_W  = 2 * CNT_W;

    // E1 decode results
    logic [CNT_W-1:0]  col_s;
    logic [CNT_W-1:0]  row_s;
    logic [GROW_W-1:0] grow_s;
    logic [BIT_W-1:0]  bit_s;
    logic              vis_s;
    logic [ADDR_W-1:0] addr_s;

    // Side-band pipeline: index n holds the value after edge En
    logic [LATENCY-1:1] vis_r;
    logic [BIT_W-1:0]   bit_r [1:LATENCY-1];
    logic [GROW_W-1:0]  grow1_r;
    logic [GROW_W-1:0]  grow2_r;

    // E5 selection
    logic [BIT_W-1:0]   pix_idx_s;
    logic               glyph_bit_s;
    logic               cur_out_s;

    // Cell decode from the raw counters (exact floor division by constants)
    always_comb begin
        col_s  = HorizontalCounter / CNT_W'(GLYPH_W);
        row_s  = VerticalCounter / CNT_W'(GLYPH_H);
        grow_s = GROW_W'(VerticalCounter % CNT_W'(GLYPH_H));
        bit_s  = BIT_W'(HorizontalCounter % CNT_W'(GLYPH_W));
        vis_s  = (HorizontalCounter < CNT_W'(H_ACTIVE)) &&
                 (VerticalCounter < CNT_W'(V_ACTIVE));
        addr_s = ADDR_W'(PROD_W'(row_s) * PROD_W'(COLS) + PROD_W'(col_s));
    end

    // E1: text RAM address and strobe; address freezes in blanking
    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            text_addr <= {ADDR_W{1'b0}};
            text_rd   <= 1'b0;
            grow1_r   <= {GROW_W{1'b0}};
        end else begin
            if (vis_s) begin
                text_addr <= addr_s;
            end
            text_rd <= vis_s;
            grow1_r <= grow_s;
        end
    end

    // Visibility and bit-position delay line running alongside the fetches
    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            vis_r <= {(LATENCY-1){1'b0}};
            for (int i = 1; i < LATENCY; i++) begin
                bit_r[i] <= {BIT_W{1'b0}};
            end
        end else begin
            vis_r    <= {vis_r[LATENCY-2:1], vis_s};
            bit_r[1] <= bit_s;
            for (int i = 2; i < LATENCY; i++) begin
                bit_r[i] <= bit_r[i-1];
            end
        end
    end

    // E2: glyph row waits while the RAM returns the character code
    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            grow2_r <= {GROW_W{1'b0}};
        end else begin
            grow2_r <= grow1_r;
        end
    end

    // E3: font ROM address and strobe; address freezes in blanking
    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            font_addr <= {FONT_AW{1'b0}};
            font_rd   <= 1'b0;
        end else begin
            if (vis_r[2]) begin
                font_addr <= {text_data, grow2_r};
            end
            font_rd <= vis_r[2];
        end
    end

    // Pick the glyph bit for the current pixel according to bit order
    always_comb begin
        if (MSB_FIRST != 0) begin
            pix_idx_s = BIT_W'(GLYPH_W - 1) - bit_r[LATENCY-1];
        end else begin
            pix_idx_s = bit_r[LATENCY-1];
        end
        glyph_bit_s = font_data[pix_idx_s];
    end

`ifdef TEXT_CURSOR_EN
    logic [CNT_W-1:0]   v_prev_r;
    logic [5:0]         blink_r;
    logic               frame_tick_s;
    logic               cur_s;
    logic [LATENCY-1:1] cur_r;

    // Frame start is V stepping to 0 at H=0; cursor hit uses E1 decode
    always_comb begin
        frame_tick_s = (VerticalCounter == {CNT_W{1'b0}}) &&
                       (HorizontalCounter == {CNT_W{1'b0}}) &&
                       (v_prev_r != {CNT_W{1'b0}});
        cur_s = cursor_on && blink_r[5] &&
                (col_s == CNT_W'(cursor_col)) &&
                (row_s == CNT_W'(cursor_row)) &&
                ((grow_s == GROW_W'(GLYPH_H - 2)) ||
                 (grow_s == GROW_W'(GLYPH_H - 1)));
    end

    // Frame counter; bit 5 is the blink phase, toggling every 32 frames
    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            v_prev_r <= {CNT_W{1'b0}};
            blink_r  <= 6'd0;
        end else begin
            v_prev_r <= VerticalCounter;
            if (frame_tick_s) begin
                blink_r <= blink_r + 6'd1;
            end
        end
    end

    // Cursor hit travels with the pixel so latency is unchanged
    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            cur_r <= {(LATENCY-1){1'b0}};
        end else begin
            cur_r <= {cur_r[LATENCY-2:1], cur_s};
        end
    end

    // Cursor contribution at the output stage
    always_comb begin
        cur_out_s = cur_r[LATENCY-1];
    end
`else
    // No cursor: pixel is purely glyph-derived
    always_comb begin
        cur_out_s = 1'b0;
    end
`endif

    // E5: registered pixel and visible flag
    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            Pixel    <= 1'b0;
            video_on <= 1'b0;
        end else begin
            Pixel    <= vis_r[LATENCY-1] & (glyph_bit_s | cur_out_s);
            video_on <= vis_r[LATENCY-1];
        end
    end

endmodule
